ann_stimulus_sequencer: RTL and testbench

Parametrised stimulus and capture engine for the drowsiness ANN on the DE2 board. It builds an N_IN-element feature vector from a selectable pattern source: constant, zero, ramp or an external stream. It then issues a one-cycle start to the detector, waits for its done flag, and latches the N_OUT results for HEX/LED display. It supersedes hard-wired switch-selected input arrays with a sequenced, handshaked fill.

---
 rtl/ann_seq_pkg.sv | 21 ++
 rtl/ann_pattern_gen.sv | 27 ++
 rtl/ann_stimulus_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_ann_stimulus_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_seq_pkg.sv
// rtl/ann_seq_pkg.sv - shared state codes, pattern modes and default sizes for the ANN stimulus sequencer
package ann_seq_pkg;

   localparam int N_IN_DEF   = 30;
   localparam int DATA_W_DEF = 10;
   localparam int N_OUT_DEF  = 3;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_FILL  = 4'd1,
      ST_ARM   = 4'd2,
      ST_WAIT  = 4'd3,
      ST_FAULT = 4'd4
   } seq_state_e;

   localparam logic [1:0] MODE_CONST = 2'b00;
   localparam logic [1:0] MODE_ZERO  = 2'b01;
   localparam logic [1:0] MODE_RAMP  = 2'b10;
   localparam logic [1:0] MODE_EXT   = 2'b11;

endpackage

// File: rtl/ann_pattern_gen.sv
// rtl/ann_pattern_gen.sv - combinational feature element generator (const / zero / ramp / external)
module ann_pattern_gen
   import ann_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int IDX_W  = 5
) (
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] const_val,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] ext_data,
   output logic [DATA_W-1:0] elem
);

   // ramp wraps modulo 2^DATA_W because the sum is kept at DATA_W bits
   always_comb begin
      elem = '0;
      case (mode)
         MODE_CONST: elem = const_val;
         MODE_ZERO:  elem = '0;
         MODE_RAMP:  elem = const_val + DATA_W'(idx);
         MODE_EXT:   elem = ext_data;
         default:    elem = '0;
      endcase
   end

endmodule

// File: rtl/ann_stimulus_sequencer.sv
// rtl/ann_stimulus_sequencer.sv - fill/start/wait/capture sequencer for the drowsiness ANN; optional watchdog via SEQ_TIMEOUT_EN
module ann_stimulus_sequencer
   import ann_seq_pkg::*;
#(
   parameter int N_IN        = N_IN_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int N_OUT       = N_OUT_DEF,
   parameter int RUN_CNT_W   = 8,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic                    Clock,
   input  logic                    Rst,
   input  logic [1:0]              mode_sel,
   input  logic [DATA_W-1:0]       const_val,
   input  logic                    go,
   input  logic [DATA_W-1:0]       ext_data,
   input  logic                    ext_valid,
   output logic                    ext_ready,
   output logic                    ann_start,
   input  logic                    ann_done,
   input  logic [N_OUT*DATA_W-1:0] ann_out,
   output logic [N_IN*DATA_W-1:0]  in_vec,
   output logic [N_OUT*DATA_W-1:0] res_vec,
   output logic                    res_valid,
   output logic                    busy,
   output logic [3:0]              state,
   output logic [RUN_CNT_W-1:0]    run_count,
   output logic                    timeout
);

   localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

   seq_state_e              state_q, state_d;
   logic [1:0]              mode_q, mode_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [N_IN*DATA_W-1:0]  in_vec_q, in_vec_d;
   logic [N_OUT*DATA_W-1:0] res_vec_q, res_vec_d;
   logic                    res_valid_q, res_valid_d;
   logic [RUN_CNT_W-1:0]    run_count_q, run_count_d;
   logic                    go_q, go_d;
   logic                    ann_start_q, ann_start_d;
   logic                    ext_ready_q, ext_ready_d;
   logic                    busy_q, busy_d;
   logic                    go_edge;
   logic                    beat;
   logic [DATA_W-1:0]       elem;

`ifdef SEQ_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
   logic            timeout_q, timeout_d;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

   ann_pattern_gen #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_pattern_gen (
      .mode      (mode_q),
      .const_val (const_val),
      .idx       (idx_q),
      .ext_data  (ext_data),
      .elem      (elem)
   );

   assign go_edge = go & ~go_q;
   assign beat    = (state_q == ST_FILL) &&
                    ((mode_q != MODE_EXT) || (ext_valid && ext_ready_q));

   // next-state logic: run sequencing, element writes and result capture
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      idx_d       = idx_q;
      in_vec_d    = in_vec_q;
      res_vec_d   = res_vec_q;
      res_valid_d = res_valid_q;
      run_count_d = run_count_q;
      go_d        = go;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
`endif
      case (state_q)
         ST_IDLE, ST_FAULT: begin
            if (go_edge) begin
               idx_d       = '0;
               res_valid_d = 1'b0;
               mode_d      = mode_sel;
               state_d     = ST_FILL;
`ifdef SEQ_TIMEOUT_EN
               timeout_d   = 1'b0;
`endif
            end
         end
         ST_FILL: begin
            if (beat) begin
               in_vec_d[idx_q*DATA_W +: DATA_W] = elem;
               if (idx_q == IDX_W'(N_IN - 1)) begin
                  state_d = ST_ARM;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_ARM: begin
            state_d = ST_WAIT;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end
         ST_WAIT: begin
            if (ann_done) begin
               res_vec_d   = ann_out;
               res_valid_d = 1'b1;
               run_count_d = run_count_q + RUN_CNT_W'(1);
               state_d     = ST_IDLE;
            end
`ifdef SEQ_TIMEOUT_EN
            else if (wait_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
               state_d   = ST_FAULT;
               timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + TO_W'(1);
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      ann_start_d = (state_d == ST_ARM);
      ext_ready_d = (state_d == ST_FILL) && (mode_d == MODE_EXT);
      busy_d      = (state_d != ST_IDLE) && (state_d != ST_FAULT);
   end

   // single state register for the FSM and all registered outputs
   always_ff @(posedge Clock) begin
      if (!Rst) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_CONST;
         idx_q       <= '0;
         in_vec_q    <= '0;
         res_vec_q   <= '0;
         res_valid_q <= 1'b0;
         run_count_q <= '0;
         go_q        <= 1'b0;
         ann_start_q <= 1'b0;
         ext_ready_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         idx_q       <= idx_d;
         in_vec_q    <= in_vec_d;
         res_vec_q   <= res_vec_d;
         res_valid_q <= res_valid_d;
         run_count_q <= run_count_d;
         go_q        <= go_d;
         ann_start_q <= ann_start_d;
         ext_ready_q <= ext_ready_d;
         busy_q      <= busy_d;
`ifdef SEQ_TIMEOUT_EN
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign state     = state_q;
   assign in_vec    = in_vec_q;
   assign res_vec   = res_vec_q;
   assign res_valid = res_valid_q;
   assign run_count = run_count_q;
   assign ann_start = ann_start_q;
   assign ext_ready = ext_ready_q;
   assign busy      = busy_q;
`ifdef SEQ_TIMEOUT_EN
   assign timeout   = timeout_q;
`else
   assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_ann_stimulus_sequencer.sv
// tb/tb_ann_stimulus_sequencer.sv - directed self-checking bench for ann_stimulus_sequencer
module tb_ann_stimulus_sequencer;

   localparam int N_IN  = 30;
   localparam int DW    = 10;
   localparam int NO    = 3;
   localparam int RCW   = 8;
   localparam int TOC   = 16;
   localparam int VW    = N_IN * DW;

   logic            Clock = 1'b0;
   logic            Rst = 1'b0;
   logic [1:0]      mode_sel = 2'b00;
   logic [DW-1:0]   const_val = '0;
   logic            go = 1'b0;
   logic [DW-1:0]   ext_data = '0;
   logic            ext_valid = 1'b0;
   logic            ext_ready;
   logic            ann_start;
   logic            ann_done = 1'b0;
   logic [NO*DW-1:0] ann_out = '0;
   logic [VW-1:0]   in_vec;
   logic [NO*DW-1:0] res_vec;
   logic            res_valid;
   logic            busy;
   logic [3:0]      state;
   logic [RCW-1:0]  run_count;
   logic            timeout;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 Clock = ~Clock;

   ann_stimulus_sequencer #(
      .N_IN        (N_IN),
      .DATA_W      (DW),
      .N_OUT       (NO),
      .RUN_CNT_W   (RCW),
      .TIMEOUT_CYC (TOC)
   ) dut (
      .Clock     (Clock),
      .Rst       (Rst),
      .mode_sel  (mode_sel),
      .const_val (const_val),
      .go        (go),
      .ext_data  (ext_data),
      .ext_valid (ext_valid),
      .ext_ready (ext_ready),
      .ann_start (ann_start),
      .ann_done  (ann_done),
      .ann_out   (ann_out),
      .in_vec    (in_vec),
      .res_vec   (res_vec),
      .res_valid (res_valid),
      .busy      (busy),
      .state     (state),
      .run_count (run_count),
      .timeout   (timeout)
   );

   task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic pulse_go();
      go = 1'b1;
      step();
      go = 1'b0;
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (ann_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic finish_run();
      step();
      ann_done = 1'b1;
      step();
      ann_done = 1'b0;
   endtask

   function automatic logic [VW-1:0] vec_const(input logic [DW-1:0] v);
      logic [VW-1:0] r;
      for (int i = 0; i < N_IN; i++) r[i*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [VW-1:0] vec_ramp(input logic [DW-1:0] base);
      logic [VW-1:0] r;
      logic [DW-1:0] e;
      for (int i = 0; i < N_IN; i++) begin
         e = base + DW'(i);
         r[i*DW +: DW] = e;
      end
      return r;
   endfunction

   initial begin
      bit ok;
      int beats;
      int cyc;
      int bad_ready;
      int early_start;
      int fire;
      int starts;
      logic [VW-1:0] exp_vec;

      // reset state
      step(2);
      check("rst_state", state, 4'd0);
      check("rst_in_vec", in_vec, '0);
      check("rst_res_vec", res_vec, '0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_ann_start", ann_start, 1'b0);
      check("rst_ext_ready", ext_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_timeout", timeout, 1'b0);
      check("rst_run_count", run_count, '0);
      Rst = 1'b1;
      step();

      // const 200; mode change and go edge during FILL must be ignored
      mode_sel = 2'b00;
      const_val = 10'd200;
      pulse_go();
      check("const_fill_state", state, 4'd1);
      check("const_busy", busy, 1'b1);
      mode_sel = 2'b10;
      step(9);
      pulse_go();
      step(19);
      check("const_no_early_start", ann_start, 1'b0);
      step();
      check("const_start", ann_start, 1'b1);
      check("const_arm_state", state, 4'd2);
      check("const_in_vec", in_vec, vec_const(10'd200));
      step();
      check("const_start_one_cycle", ann_start, 1'b0);
      check("const_wait_state", state, 4'd3);

      // capture with a go edge on the same cycle as ann_done
      check("wait_res_valid_low", res_valid, 1'b0);
      ann_out = {10'd9, 10'd7, 10'd5};
      ann_done = 1'b1;
      go = 1'b1;
      step();
      ann_done = 1'b0;
      go = 1'b0;
      check("cap_res_vec", res_vec, {10'd9, 10'd7, 10'd5});
      check("cap_res_valid", res_valid, 1'b1);
      check("cap_run_count", run_count, 8'd1);
      check("cap_state_idle", state, 4'd0);
      step();
      check("go_with_done_ignored", state, 4'd0);

      // ann_done outside WAIT is ignored
      ann_out = {10'd1, 10'd2, 10'd3};
      ann_done = 1'b1;
      step();
      ann_done = 1'b0;
      check("idle_done_res_vec", res_vec, {10'd9, 10'd7, 10'd5});
      check("idle_done_run_count", run_count, 8'd1);
      check("res_valid_held", res_valid, 1'b1);

      // ramp with wrap
      mode_sel = 2'b10;
      const_val = 10'd1020;
      pulse_go();
      check("go_clears_res_valid", res_valid, 1'b0);
      wait_start(ok);
      check("ramp_start_seen", ok, 1'b1);
      check("ramp_e0", in_vec[0*DW +: DW], 10'd1020);
      check("ramp_e3", in_vec[3*DW +: DW], 10'd1023);
      check("ramp_e4", in_vec[4*DW +: DW], 10'd0);
      check("ramp_e29", in_vec[29*DW +: DW], 10'd25);
      check("ramp_in_vec", in_vec, vec_ramp(10'd1020));
      finish_run();
      check("ramp_run_count", run_count, 8'd2);

      // external stream, valid every other cycle
      mode_sel = 2'b11;
      check("ext_ready_idle", ext_ready, 1'b0);
      pulse_go();
      beats = 0;
      cyc = 0;
      bad_ready = 0;
      early_start = 0;
      while (beats < N_IN && cyc < 200) begin
         if (ext_ready !== 1'b1) bad_ready++;
         if (ann_start !== 1'b0) early_start++;
         ext_valid = cyc[0];
         ext_data = DW'(beats);
         fire = (ext_valid && ext_ready) ? 1 : 0;
         step();
         beats += fire;
         cyc++;
      end
      ext_valid = 1'b0;
      check("ext_beats", beats, N_IN);
      check("ext_ready_in_fill", bad_ready, 0);
      check("ext_no_early_start", early_start, 0);
      check("ext_start", ann_start, 1'b1);
      check("ext_ready_after_fill", ext_ready, 1'b0);
      for (int i = 0; i < N_IN; i++) exp_vec[i*DW +: DW] = DW'(i);
      check("ext_in_vec", in_vec, exp_vec);
      finish_run();
      check("ext_run_count", run_count, 8'd3);

      // zero mode
      mode_sel = 2'b01;
      pulse_go();
      wait_start(ok);
      check("zero_start_seen", ok, 1'b1);
      check("zero_in_vec", in_vec, '0);
      finish_run();

      // run counter wrap
      mode_sel = 2'b00;
      const_val = 10'd3;
      for (int r = 0; r < 300 && run_count != 8'd255; r++) begin
         pulse_go();
         wait_start(ok);
         finish_run();
      end
      check("count_at_255", run_count, 8'd255);
      pulse_go();
      wait_start(ok);
      finish_run();
      check("count_wrap", run_count, 8'd0);

      // reset during FILL at idx 12
      const_val = 10'd77;
      pulse_go();
      step(12);
      Rst = 1'b0;
      step();
      check("midrst_state", state, 4'd0);
      check("midrst_in_vec", in_vec, '0);
      check("midrst_run_count", run_count, '0);
      check("midrst_res_valid", res_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      Rst = 1'b1;
      starts = 0;
      for (int i = 0; i < 40; i++) begin
         if (ann_start !== 1'b0) starts++;
         step();
      end
      check("midrst_no_start", starts, 0);
      pulse_go();
      wait_start(ok);
      check("post_rst_start_seen", ok, 1'b1);
      check("post_rst_in_vec", in_vec, vec_const(10'd77));
      finish_run();
      check("post_rst_run_count", run_count, 8'd1);
      check("post_rst_res_valid", res_valid, 1'b1);

      // watchdog
      pulse_go();
      wait_start(ok);
      step();
      check("wd_wait_state", state, 4'd3);
`ifdef SEQ_TIMEOUT_EN
      step(15);
      check("wd_still_wait", state, 4'd3);
      check("wd_not_yet", timeout, 1'b0);
      step();
      check("wd_fault_state", state, 4'd4);
      check("wd_timeout", timeout, 1'b1);
      check("wd_busy", busy, 1'b0);
      check("wd_res_valid", res_valid, 1'b0);
      check("wd_run_count", run_count, 8'd1);
      pulse_go();
      check("wd_clear", timeout, 1'b0);
      check("wd_refill", state, 4'd1);
      wait_start(ok);
      check("wd_restart_seen", ok, 1'b1);
      finish_run();
      check("wd_restart_count", run_count, 8'd2);
`else
      step(40);
      check("nowd_still_wait", state, 4'd3);
      check("nowd_timeout", timeout, 1'b0);
      finish_run();
      check("nowd_run_count", run_count, 8'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
